// File: rtl/chk_window_pkg.sv
// Shared types and checker bit positions for the checker qualify-window generator.
package chk_window_pkg;

  // Checker-3 arming FSM; encoding is visible on the debug state output.
  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    GUARD   = 2'd1,
    RUN     = 2'd2
  } state_e;

  // Only this enable-vector width is supported by the bit map below.
  localparam int NUM_CHK_REQ = 32'd9;

  // Enable bit index k drives checker ID k+1.
  localparam int CHK_VSO   = 32'd0;  // post-scale vsync checker
  localparam int CHK_APB   = 32'd1;  // APB / input vsync checker
  localparam int CHK_VSI   = 32'd2;  // input vsync checker, needs guard
  localparam int CHK_CS    = 32'd3;  // any-SRAM-selected checker
  localparam int CHK_SRAM1 = 32'd4;  // SRAM1 write checker
  localparam int CHK_SRAM2 = 32'd5;  // SRAM2 write checker
  localparam int CHK_SRAM3 = 32'd6;  // SRAM3 write checker
  localparam int CHK_SRAM4 = 32'd7;  // SRAM4 write checker
  localparam int CHK_MUX   = 32'd8;  // scaler mode mux checker

endpackage

// File: rtl/chk_stable_det.sv
// Change detector with a saturating run-length counter. "stable" rises once
// the watched value has been unchanged for STABLE_CNT consecutive cycles;
// "qualified" additionally drops in the very cycle a change is observed so a
// downstream register can react without waiting for stable to clear.
module chk_stable_det #(
  parameter int WIDTH      = 1,
  parameter int STABLE_CNT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  output logic             stable,
  output logic             qualified
);

  localparam int            CW      = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
  localparam logic [CW-1:0] CNT_INC = CW'(32'd1);

  logic [WIDTH-1:0] prev_r;
  logic [CW-1:0]    cnt_r;
  logic             stable_r;
  logic             change_s;
  logic [CW-1:0]    cnt_nxt_s;
  logic             stable_nxt_s;

  // Compare against last cycle's value and compute the next run length.
  always_comb begin
    change_s     = (value != prev_r);
    cnt_nxt_s    = cnt_r;
    stable_nxt_s = stable_r;
    if (change_s) begin
      cnt_nxt_s    = {CW{1'b0}};
      stable_nxt_s = 1'b0;
    end else begin
      if (cnt_r == CNT_MAX) begin
        cnt_nxt_s = cnt_r;
      end else begin
        cnt_nxt_s = cnt_r + CNT_INC;
      end
      stable_nxt_s = (cnt_nxt_s == CNT_MAX);
    end
  end

  // Hold previous value, run-length counter and stable flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r   <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      stable_r <= 1'b0;
    end else begin
      prev_r   <= value;
      cnt_r    <= cnt_nxt_s;
      stable_r <= stable_nxt_s;
    end
  end

  assign stable    = stable_r;
  assign qualified = stable_r & ~change_s;

endmodule

// File: rtl/chk_window_gen.sv
// Per-checker qualify-enable generator: turns video sync, APB, SRAM and
// scaler-mode activity into one registered enable bit per assertion checker.
module chk_window_gen
  import chk_window_pkg::*;
#(
  parameter int NUM_CHK    = 9,
  parameter int VS_GUARD   = 3,
  parameter int STABLE_CNT = 10,
  parameter int APB_HOLD   = 2
) (
  input  logic               I_CLK,
  input  logic               I_RST,
  input  logic [NUM_CHK-1:0] I_WAIVE,
  input  logic               I_VSYNC_IN,
  input  logic               I_VSYNC_SCALE,
  input  logic               I_PSEL,
  input  logic               I_PEN,
  input  logic [3:0]         I_CS,
  input  logic [3:0]         I_WE,
  input  logic               I_MIRROR_MODE,
  input  logic               I_BLUR_MODE,
  output logic [NUM_CHK-1:0] O_CHK_EN,
  output logic [1:0]         O_STATE,
  output logic               O_MODE_STABLE
);

  localparam int            GW        = $clog2(VS_GUARD + 1);
  localparam logic [GW-1:0] GUARD_MAX = GW'(VS_GUARD);
  localparam logic [GW-1:0] GUARD_INC = GW'(32'd1);
  localparam int            HW        = $clog2(APB_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(APB_HOLD);
  localparam logic [HW-1:0] HOLD_DEC  = HW'(32'd1);

  // The enable bit map is fixed; any other width is a configuration error.
  if (NUM_CHK != NUM_CHK_REQ) begin : g_bad_num_chk
    $error("chk_window_gen: NUM_CHK must be 9");
  end

  logic               vs_seen_r;
  logic               vss_seen_r;
  state_e             state_r;
  state_e             state_nxt_s;
  logic [GW-1:0]      guard_cnt_r;
  logic [GW-1:0]      guard_cnt_nxt_s;
  logic               apb_act_s;
  logic [HW-1:0]      apb_hold_r;
  logic               scaler_on_s;
  logic               mode_stable_s;
  logic               mode_qual_s;
  logic [NUM_CHK-1:0] raw_en_s;
  logic [NUM_CHK-1:0] chk_en_r;

  assign apb_act_s   = I_PSEL & I_PEN;
  assign scaler_on_s = I_MIRROR_MODE | I_BLUR_MODE;

  // Sticky "sync has been seen at least once" flags.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      vs_seen_r  <= 1'b0;
      vss_seen_r <= 1'b0;
    end else begin
      vs_seen_r  <= vs_seen_r | I_VSYNC_IN;
      vss_seen_r <= vss_seen_r | I_VSYNC_SCALE;
    end
  end

  // Arming FSM next state: a vsync seen during GUARD is ignored on purpose,
  // so the guard window is a fixed length from the first vsync.
  always_comb begin
    state_nxt_s     = state_r;
    guard_cnt_nxt_s = guard_cnt_r;
    case (state_r)
      WAIT_VS: begin
        guard_cnt_nxt_s = {GW{1'b0}};
        if (I_VSYNC_IN) begin
          state_nxt_s = GUARD;
        end else begin
          state_nxt_s = WAIT_VS;
        end
      end
      GUARD: begin
        guard_cnt_nxt_s = guard_cnt_r + GUARD_INC;
        if (guard_cnt_nxt_s == GUARD_MAX) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = GUARD;
        end
      end
      RUN: begin
        state_nxt_s     = RUN;
        guard_cnt_nxt_s = guard_cnt_r;
      end
      default: begin
        state_nxt_s     = WAIT_VS;
        guard_cnt_nxt_s = {GW{1'b0}};
      end
    endcase
  end

  // Arming FSM state and guard counter registers.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_r     <= WAIT_VS;
      guard_cnt_r <= {GW{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      guard_cnt_r <= guard_cnt_nxt_s;
    end
  end

  // APB tail: reload on every access cycle, then count down to zero.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      apb_hold_r <= {HW{1'b0}};
    end else if (apb_act_s) begin
      apb_hold_r <= HOLD_MAX;
    end else if (apb_hold_r != {HW{1'b0}}) begin
      apb_hold_r <= apb_hold_r - HOLD_DEC;
    end else begin
      apb_hold_r <= apb_hold_r;
    end
  end

  chk_stable_det #(
    .WIDTH      (1),
    .STABLE_CNT (STABLE_CNT)
  ) u_mode_det (
    .clk       (I_CLK),
    .rst       (I_RST),
    .value     (scaler_on_s),
    .stable    (mode_stable_s),
    .qualified (mode_qual_s)
  );

  // Raw enable conditions; every off-condition and the waiver mask win.
  always_comb begin
    raw_en_s            = {NUM_CHK{1'b0}};
    raw_en_s[CHK_VSO]   = vss_seen_r & ~I_VSYNC_SCALE;
    raw_en_s[CHK_APB]   = vs_seen_r & ~apb_act_s & (apb_hold_r == {HW{1'b0}}) & ~I_VSYNC_IN;
    raw_en_s[CHK_VSI]   = (state_r == RUN) & ~I_VSYNC_IN;
    raw_en_s[CHK_CS]    = ~|I_CS;
    raw_en_s[CHK_SRAM1] = ~(I_CS[0] & I_WE[0]);
    raw_en_s[CHK_SRAM2] = ~(I_CS[1] & I_WE[1]);
    raw_en_s[CHK_SRAM3] = ~(I_CS[2] & I_WE[2]);
    raw_en_s[CHK_SRAM4] = ~(I_CS[3] & I_WE[3]);
    raw_en_s[CHK_MUX]   = mode_qual_s;
    raw_en_s            = raw_en_s & ~I_WAIVE;
  end

  // Register the enables so downstream sees a clean one-cycle-late view.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      chk_en_r <= {NUM_CHK{1'b0}};
    end else begin
      chk_en_r <= raw_en_s;
    end
  end

  assign O_CHK_EN      = chk_en_r;
  assign O_STATE       = state_r;
  assign O_MODE_STABLE = mode_stable_s;

endmodule

// File: tb/tb_chk_window_gen.sv
// Directed bench for chk_window_gen: linear stimulus, hand-computed expectations.
module tb_chk_window_gen;

  logic       clk;
  logic       rst;
  logic [8:0] waive;
  logic       vsync_in;
  logic       vsync_scale;
  logic       psel;
  logic       pen;
  logic [3:0] cs;
  logic [3:0] we;
  logic       mirror;
  logic       blur;
  logic [8:0] chk_en;
  logic [1:0] state;
  logic       mode_stable;

  int cyc;
  int chk_cnt;
  int err_cnt;

  chk_window_gen #(
    .NUM_CHK    (9),
    .VS_GUARD   (3),
    .STABLE_CNT (10),
    .APB_HOLD   (2)
  ) dut (
    .I_CLK         (clk),
    .I_RST         (rst),
    .I_WAIVE       (waive),
    .I_VSYNC_IN    (vsync_in),
    .I_VSYNC_SCALE (vsync_scale),
    .I_PSEL        (psel),
    .I_PEN         (pen),
    .I_CS          (cs),
    .I_WE          (we),
    .I_MIRROR_MODE (mirror),
    .I_BLUR_MODE   (blur),
    .O_CHK_EN      (chk_en),
    .O_STATE       (state),
    .O_MODE_STABLE (mode_stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    cyc = 0; chk_cnt = 0; err_cnt = 0;
    rst = 1'b1; waive = 9'h000; vsync_in = 1'b0; vsync_scale = 1'b0;
    psel = 1'b0; pen = 1'b0; cs = 4'h0; we = 4'h0; mirror = 1'b0; blur = 1'b0;
    tick(); tick(); tick();
    check("rst_en", 32'(chk_en), 32'h000);
    check("rst_state", 32'(state), 32'd0);
    check("rst_stable", 32'(mode_stable), 32'd0);

    // Cycle 0: reset released; inputs driven in cycle n are sampled at its end.
    rst = 1'b0; cyc = 0;
    goto(1);  check("idle_en_c1", 32'(chk_en), 32'h0F8);
    goto(9);  check("stable_c9", 32'(mode_stable), 32'd0);
    goto(10); check("stable_c10", 32'(mode_stable), 32'd1);
              check("en_c10", 32'(chk_en), 32'h0F8);
    goto(11); check("en_c11", 32'(chk_en), 32'h1F8);
    goto(50); check("idle_en_c50", 32'(chk_en), 32'h1F8);
              check("idle_state_c50", 32'(state), 32'd0);

    // Input vsync high for cycles 60..64.
    goto(60); check("state_c60", 32'(state), 32'd0);
    vsync_in = 1'b1;
    goto(61); check("state_c61", 32'(state), 32'd1);
    goto(63); check("state_c63", 32'(state), 32'd1);
    goto(64); check("state_c64", 32'(state), 32'd2);
    goto(65); check("vs_en_c65", 32'(chk_en), 32'h1F8);
    vsync_in = 1'b0;
    goto(66); check("vs_en_c66", 32'(chk_en), 32'h1FE);

    // APB access on cycles 80..81, then a PSEL-only cycle at 90.
    goto(80); check("apb_en_c80", 32'(chk_en), 32'h1FE);
    psel = 1'b1; pen = 1'b1;
    goto(81); check("apb_en_c81", 32'(chk_en), 32'h1FC);
    goto(82); psel = 1'b0; pen = 1'b0;
    goto(84); check("apb_en_c84", 32'(chk_en), 32'h1FC);
    goto(85); check("apb_en_c85", 32'(chk_en), 32'h1FE);
    goto(90); psel = 1'b1;
    goto(91); check("psel_only_c91", 32'(chk_en), 32'h1FE);
    psel = 1'b0;

    // SRAM3 write for cycles 100..102; SRAM1 select without write at 110.
    goto(100); check("cs_en_c100", 32'(chk_en), 32'h1FE);
    cs = 4'b0100; we = 4'b0100;
    goto(101); check("cs_en_c101", 32'(chk_en), 32'h1B6);
    goto(103); check("cs_en_c103", 32'(chk_en), 32'h1B6);
    cs = 4'b0000; we = 4'b0000;
    goto(104); check("cs_en_c104", 32'(chk_en), 32'h1FE);
    goto(110); cs = 4'b0001;
    goto(111); check("cs_only_c111", 32'(chk_en), 32'h1F6);
    cs = 4'b0000;

    // Mirror 0->1 at 130, back 1->0 at 135: re-enable pushed to 147.
    goto(130); check("mode_en_c130", 32'(chk_en), 32'h1FE);
    mirror = 1'b1;
    goto(131); check("mode_en_c131", 32'(chk_en), 32'h0FE);
               check("mode_stable_c131", 32'(mode_stable), 32'd0);
    goto(135); mirror = 1'b0;
    goto(145); check("mode_stable_c145", 32'(mode_stable), 32'd0);
    goto(146); check("mode_stable_c146", 32'(mode_stable), 32'd1);
               check("mode_en_c146", 32'(chk_en), 32'h0FE);
    goto(147); check("mode_en_c147", 32'(chk_en), 32'h1FE);

    // Single blur toggle at 160: stable back at 171, bit8 at 172.
    goto(160); blur = 1'b1;
    goto(161); check("blur_en_c161", 32'(chk_en), 32'h0FE);
    goto(170); check("blur_stable_c170", 32'(mode_stable), 32'd0);
    goto(171); check("blur_stable_c171", 32'(mode_stable), 32'd1);
               check("blur_en_c171", 32'(chk_en), 32'h0FE);
    goto(172); check("blur_en_c172", 32'(chk_en), 32'h1FE);
    // Mirror on while blur already on: scaler_on unchanged.
    goto(180); mirror = 1'b1;
    goto(181); check("both_on_c181", 32'(chk_en), 32'h1FE);

    // Post-scale vsync at 190..191; single input vsync at 200.
    goto(190); vsync_scale = 1'b1;
    goto(192); check("vss_en_c192", 32'(chk_en), 32'h1FE);
    vsync_scale = 1'b0;
    goto(193); check("vss_en_c193", 32'(chk_en), 32'h1FF);
    goto(200); vsync_in = 1'b1;
    goto(201); check("vsin_en_c201", 32'(chk_en), 32'h1F9);
    vsync_in = 1'b0;
    goto(202); check("vsin_en_c202", 32'(chk_en), 32'h1FF);
               check("run_state_c202", 32'(state), 32'd2);

    // Waiver mask.
    goto(210); waive = 9'h1FF;
    goto(211); check("waive_all_c211", 32'(chk_en), 32'h000);
    waive = 9'h001;
    goto(212); check("waive_b0_c212", 32'(chk_en), 32'h1FE);
    waive = 9'h000;
    goto(213); check("waive_off_c213", 32'(chk_en), 32'h1FF);

    // Reset while in RUN.
    goto(220); rst = 1'b1;
    goto(221); check("rst_run_en", 32'(chk_en), 32'h000);
               check("rst_run_state", 32'(state), 32'd0);
               check("rst_run_stable", 32'(mode_stable), 32'd0);
    rst = 1'b0;
    goto(223); check("post_rst_en_c223", 32'(chk_en), 32'h0F8);
               check("post_rst_state_c223", 32'(state), 32'd0);
    // Vsync at 225, second vsync mid-guard at 227 must not extend the guard.
    goto(225); vsync_in = 1'b1;
    goto(226); check("guard_state_c226", 32'(state), 32'd1);
    vsync_in = 1'b0;
    goto(227); vsync_in = 1'b1;
    goto(228); check("guard_state_c228", 32'(state), 32'd1);
    vsync_in = 1'b0;
    goto(229); check("guard_state_c229", 32'(state), 32'd2);

    // Reset, then reset again in the middle of GUARD.
    goto(240); rst = 1'b1;
    goto(241); rst = 1'b0;
    goto(243); vsync_in = 1'b1;
    goto(244); check("guard2_state_c244", 32'(state), 32'd1);
    vsync_in = 1'b0;
    goto(245); rst = 1'b1;
    goto(246); check("rst_guard_en", 32'(chk_en), 32'h000);
               check("rst_guard_state", 32'(state), 32'd0);
    rst = 1'b0;
    goto(250); check("rst_guard_state_c250", 32'(state), 32'd0);
               check("rst_guard_en_c250", 32'(chk_en), 32'h0F8);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
